// File: rtl/fxp_to_flp_stream_converter.sv
// Streams a vector of signed fixed-point samples out as floats, one channel per cycle.
// Two-stage pipeline: magnitude/leading-one detect, then normalise/round into {sign, exp, mant}.
//   state     | meaning
//   S_IDLE    | waiting for an input vector, S_READY high
//   S_CONVERT | issuing buffered channels and draining the pipeline
module fxp_to_flp_stream_converter #(
  parameter int C_FXP_WIDTH      = 16,
  parameter int C_FXP_POINT      = 12,
  parameter int C_CHANNELS       = 3,
  parameter int C_FLP_EXP_WIDTH  = 8,
  parameter int C_FLP_MANT_WIDTH = 23,
  parameter int C_ROUND          = 1,
  localparam int C_FLP_WIDTH     = 1 + C_FLP_EXP_WIDTH + C_FLP_MANT_WIDTH,
  localparam int CW              = (C_CHANNELS > 1) ? $clog2(C_CHANNELS) : 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [C_CHANNELS*C_FXP_WIDTH-1:0] S_DATA,
  input  logic                              S_VALID,
  output logic                              S_READY,
  output logic [C_FLP_WIDTH-1:0]            M_DATA,
  output logic [CW-1:0]                     M_CHAN,
  output logic                              M_ZERO,
  output logic                              M_LAST,
  output logic                              M_VALID,
  input  logic                              M_READY,
  output logic                              BUSY
);

  localparam int W    = C_FXP_WIDTH;
  localparam int E    = C_FLP_EXP_WIDTH;
  localparam int M    = C_FLP_MANT_WIDTH;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int PW   = (W > 1) ? $clog2(W) : 1;
  localparam int XW   = W + M + 1;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CONVERT = 1'b1;

  // Every representable input must land on a normal exponent.
  if ((BIAS - C_FXP_POINT < 1) || (BIAS + W - C_FXP_POINT > (1 << E) - 2)) begin : g_fmt_check
    $fatal(1, "float exponent range cannot hold the fixed-point range");
  end

  logic [0:0]              state;
  logic [C_CHANNELS*W-1:0] chan_buf;
  logic [CW-1:0]           cnt;
  logic                    issuing;
  logic                    advance;

  logic                    s1_valid;
  logic                    s1_sign;
  logic [W-1:0]            s1_mag;
  logic [PW-1:0]           s1_pos;
  logic                    s1_zero;
  logic [CW-1:0]           s1_chan;
  logic                    s1_last;

  logic [W-1:0]            sample;
  logic [W-1:0]            mag_c;
  logic [PW-1:0]           shamt;
  logic [W-1:0]            norm;
  logic [XW-1:0]           ext;
  logic [M-1:0]            mant_t;
  logic                    guard;
  logic                    sticky;
  logic                    round_up;
  logic [M:0]              mant_r;
  logic [E-1:0]            exp_c;

  function automatic logic [PW-1:0] lead_one(input logic [W-1:0] v);
    lead_one = '0;
    for (int i = 0; i < W; i++)
      if (v[i]) lead_one = PW'(i);
  endfunction

  assign advance = ~M_VALID | M_READY;
  assign S_READY = (state == S_IDLE) & ~RST;
  assign BUSY    = (state != S_IDLE);

  assign sample = chan_buf[cnt*W +: W];
  assign mag_c  = sample[W-1] ? (~sample + 1'b1) : sample;

  // Left-justify so the leading one sits at bit W-1; everything below is fraction.
  assign shamt    = PW'(W - 1) - s1_pos;
  assign norm     = s1_mag << shamt;
  assign ext      = {norm[W-2:0], {(M + 2){1'b0}}};
  assign mant_t   = ext[XW-1 -: M];
  assign guard    = ext[XW-1-M];
  assign sticky   = |ext[XW-2-M:0];
  assign round_up = (C_ROUND != 0) && guard && (sticky || mant_t[0]);
  assign mant_r   = {1'b0, mant_t} + (M + 1)'(round_up);
  assign exp_c    = E'(BIAS - C_FXP_POINT) + E'(s1_pos) + E'(mant_r[M]);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      chan_buf <= '0;
      cnt      <= '0;
      issuing  <= 1'b0;
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_mag   <= '0;
      s1_pos   <= '0;
      s1_zero  <= 1'b0;
      s1_chan  <= '0;
      s1_last  <= 1'b0;
      M_VALID  <= 1'b0;
      M_DATA   <= '0;
      M_CHAN   <= '0;
      M_ZERO   <= 1'b0;
      M_LAST   <= 1'b0;
    end else if (state == S_IDLE) begin
      if (S_VALID) begin
        chan_buf <= S_DATA;
        cnt      <= '0;
        issuing  <= 1'b1;
        state    <= S_CONVERT;
      end
    end else if (advance) begin
      s1_valid <= issuing;
      if (issuing) begin
        s1_sign <= sample[W-1];
        s1_mag  <= mag_c;
        s1_pos  <= lead_one(mag_c);
        s1_zero <= ~|sample;
        s1_chan <= cnt;
        s1_last <= (cnt == CW'(C_CHANNELS - 1));
        if (cnt == CW'(C_CHANNELS - 1)) issuing <= 1'b0;
        else                            cnt     <= cnt + 1'b1;
      end
      M_VALID <= s1_valid;
      if (s1_valid) begin
        M_DATA <= norm[W-1] ? {s1_sign, exp_c, mant_r[M-1:0]} : '0;
        M_ZERO <= s1_zero;
        M_CHAN <= s1_chan;
        M_LAST <= s1_last;
      end
      if (M_VALID & M_READY & M_LAST) state <= S_IDLE;
    end
  end

endmodule
